// File: rtl/alu_response_checker_if.sv
// Operand/result bundle between the ALU stimulus side and the response checker.
//   i_valid/i_arg0/i_arg1/i_oper : operand set issued to the ALU this cycle
//   i_end                        : single-cycle pulse, no further issues
//   i_result/i_flag              : ALU o_result / o_flag (bit0 ERR, bit1 NEG, bit2 POS, bit3 OVF)
//   o_mismatch/o_chk_cnt/o_err_cnt/o_status : checker verdict
// master = the side driving operands and ALU results, slave = the checker.
interface alu_response_checker_if #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNT_W = 8
);
    logic             i_valid;
    logic [WIDTH-1:0] i_arg0;
    logic [WIDTH-1:0] i_arg1;
    logic [1:0]       i_oper;
    logic             i_end;
    logic [WIDTH-1:0] i_result;
    logic [3:0]       i_flag;
    logic             o_mismatch;
    logic [CNT_W-1:0] o_chk_cnt;
    logic [CNT_W-1:0] o_err_cnt;
    logic [1:0]       o_status;

    modport master (
        output i_valid, i_arg0, i_arg1, i_oper, i_end, i_result, i_flag,
        input  o_mismatch, o_chk_cnt, o_err_cnt, o_status
    );

    modport slave (
        input  i_valid, i_arg0, i_arg1, i_oper, i_end, i_result, i_flag,
        output o_mismatch, o_chk_cnt, o_err_cnt, o_status
    );
endinterface

// File: rtl/alu_response_checker.sv
// Response checker for the TOP ALU: computes golden result/flags for each issued
// operand set, delays them by the ALU latency and compares against the ALU output.
// Ports:
//   i_clk : clock, rising edge
//   i_rst : asynchronous active-high reset
//   bus   : alu_response_checker_if slave (operands, end pulse, ALU response in;
//           mismatch pulse, check/error counters, status out)
// Status: 00 IDLE, 01 RUN (also while draining), 10 PASS, 11 FAIL.
module alu_response_checker #(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned LATENCY = 2,
    parameter int unsigned CNT_W   = 8
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    alu_response_checker_if.slave  bus
);

    localparam int unsigned FLAG_W = 4;
    localparam int unsigned DRN_W  = 4;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [DRN_W-1:0] DRN_LAST = DRN_W'(LATENCY - 1);

    typedef struct packed {
        logic              vld;
        logic [WIDTH-1:0]  y;
        logic [FLAG_W-1:0] flag;   // {OVF, POS, NEG, ERR}
    } entry_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_PASS,
        S_FAIL
    } state_t;

    // Golden ALU: result and flags for one operand set.
    function automatic entry_t golden(input logic [WIDTH-1:0] a,
                                      input logic [WIDTH-1:0] b,
                                      input logic [1:0]       op);
        entry_t e;
        logic   neg;
        logic   ovf;
        logic   err;
        logic   run;
        e   = '0;
        neg = 1'b0;
        ovf = 1'b0;
        err = 1'b0;
        run = 1'b1;
        case (op)
            2'b00: begin
                e.y = a - b;
                // overflow only when operand signs differ and result sign flips from A
                ovf = (a[WIDTH-1] != b[WIDTH-1]) && (e.y[WIDTH-1] != a[WIDTH-1]);
                neg = e.y[WIDTH-1];
            end
            2'b01: begin
                e.y = ~(a & b);
                neg = e.y[WIDTH-1];
            end
            2'b10: begin
                // run stays high only while every bit from the MSB down is set
                for (int i = WIDTH - 1; i >= 0; i--) begin
                    run = run & a[i];
                    if (run) begin
                        e.y = e.y + WIDTH'(1);
                    end
                end
            end
            default: begin
                if ($onehot(a)) begin
                    for (int i = 0; i < WIDTH; i++) begin
                        if (a[i]) begin
                            e.y = WIDTH'(i);
                        end
                    end
                end else begin
                    err = 1'b1;
                end
            end
        endcase
        e.flag = {ovf, ~neg & (e.y != '0), neg, err};
        e.vld  = 1'b1;
        return e;
    endfunction

    state_t           state_q, state_d;
    logic [DRN_W-1:0] drain_q, drain_d;
    logic [CNT_W-1:0] chk_q, chk_d;
    logic [CNT_W-1:0] err_q, err_d;
    logic             mis_q, mis_d;
    logic [1:0]       status_q, status_d;
    entry_t           pipe_q [LATENCY];
    entry_t           new_ent_c;
    entry_t           tail_c;
    logic             issue_c;
    logic             cmp_fail_c;

    // Next-state, compare and counter logic.
    always_comb begin
        state_d    = state_q;
        drain_d    = drain_q;
        chk_d      = chk_q;
        err_d      = err_q;
        mis_d      = 1'b0;
        issue_c    = 1'b0;
        status_d   = 2'b00;
        tail_c     = pipe_q[LATENCY-1];
        cmp_fail_c = tail_c.vld &&
                     ({bus.i_result, bus.i_flag} != {tail_c.y, tail_c.flag});

        if (tail_c.vld && (chk_q != CNT_MAX)) begin
            chk_d = chk_q + CNT_W'(1);
        end
        if (cmp_fail_c) begin
            mis_d = 1'b1;
            if (err_q != CNT_MAX) begin
                err_d = err_q + CNT_W'(1);
            end
        end

        case (state_q)
            S_IDLE, S_RUN: begin
                issue_c = bus.i_valid;
                if (bus.i_end) begin
                    state_d = S_DRAIN;
                    drain_d = '0;
                end else if (bus.i_valid) begin
                    state_d = S_RUN;
                end
            end
            S_DRAIN: begin
                // verdict uses err_d so a failure on the last drain edge is counted
                if (drain_q == DRN_LAST) begin
                    state_d = (err_d == '0) ? S_PASS : S_FAIL;
                end else begin
                    drain_d = drain_q + DRN_W'(1);
                end
            end
            default: state_d = state_q;
        endcase

        new_ent_c     = golden(bus.i_arg0, bus.i_arg1, bus.i_oper);
        new_ent_c.vld = issue_c;

        case (state_d)
            S_IDLE:  status_d = 2'b00;
            S_PASS:  status_d = 2'b10;
            S_FAIL:  status_d = 2'b11;
            default: status_d = 2'b01;
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= S_IDLE;
            drain_q  <= '0;
            chk_q    <= '0;
            err_q    <= '0;
            mis_q    <= 1'b0;
            status_q <= 2'b00;
        end else begin
            state_q  <= state_d;
            drain_q  <= drain_d;
            chk_q    <= chk_d;
            err_q    <= err_d;
            mis_q    <= mis_d;
            status_q <= status_d;
        end
    end

    // Golden delay line aligning expected values with the ALU output.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < LATENCY; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            pipe_q[0] <= new_ent_c;
            for (int i = 1; i < LATENCY; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign bus.o_mismatch = mis_q;
    assign bus.o_chk_cnt  = chk_q;
    assign bus.o_err_cnt  = err_q;
    assign bus.o_status   = status_q;

endmodule

// File: tb/tb_alu_response_checker.sv
// Scoreboard bench for alu_response_checker: a behavioural ALU stand-in feeds
// responses (optionally corrupted); a monitor pops the expected verdict for every
// compare the checker reports.
module tb_alu_response_checker;

    localparam int LAT = 2;

    logic clk;
    logic rst;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    bit        sb_q[$];       // expected mismatch bit per accepted issue
    logic [7:0] resp[int];    // ALU response {flag, result} keyed by cycle
    bit        ended;
    int        exp_err;
    int        prev_chk;
    int        mis_cnt;
    int        mis_cyc;

    alu_response_checker_if #(.WIDTH(4), .CNT_W(8)) bif ();
    alu_response_checker_if #(.WIDTH(4), .CNT_W(4)) sif ();

    alu_response_checker #(.WIDTH(4), .LATENCY(LAT), .CNT_W(8)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bif)
    );

    alu_response_checker #(.WIDTH(4), .LATENCY(LAT), .CNT_W(4)) dut_sat (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (sif)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference ALU from the arithmetic definitions; returns {OVF,POS,NEG,ERR,Y}.
    function automatic logic [7:0] ref_alu(input logic [3:0] a, input logic [3:0] b,
                                           input logic [1:0] op);
        int sa, sb, d, y;
        bit ovf, neg, pos, err;
        ovf = 0; neg = 0; err = 0; y = 0;
        sa = (a >= 8) ? int'(a) - 16 : int'(a);
        sb = (b >= 8) ? int'(b) - 16 : int'(b);
        case (op)
            2'd0: begin
                d   = sa - sb;
                ovf = (d > 7) || (d < -8);
                y   = (int'(a) - int'(b) + 16) % 16;
                neg = (y >= 8);
            end
            2'd1: begin
                y   = 15 - int'(a & b);
                neg = (y >= 8);
            end
            2'd2: begin
                while (y < 4 && a[3 - y]) y++;
            end
            default: begin
                if ($countones(a) == 1) begin
                    for (int i = 0; i < 4; i++) if (int'(a) == (1 << i)) y = i;
                end else begin
                    err = 1;
                end
            end
        endcase
        pos = !neg && (y != 0);
        return {ovf, pos, neg, err, 4'(y)};
    endfunction

    // ALU stand-in: present the scheduled response, junk otherwise.
    always @(negedge clk) begin
        if (resp.exists(cyc)) begin
            {bif.i_flag, bif.i_result} = resp[cyc];
            resp.delete(cyc);
        end else begin
            bif.i_result = 4'($urandom);
            bif.i_flag   = 4'($urandom);
        end
    end

    // Monitor: every checker compare pops one expected verdict.
    always @(negedge clk) begin
        if (rst) begin
            prev_chk = int'(bif.o_chk_cnt);
        end else begin
            if (int'(bif.o_chk_cnt) != prev_chk) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_compare", int'(bif.o_chk_cnt), prev_chk);
                end else begin
                    bit exp_mis;
                    exp_mis = sb_q.pop_front();
                    if (exp_mis) exp_err++;
                    check("chk_step", int'(bif.o_chk_cnt), prev_chk + 1);
                    check("mismatch", int'(bif.o_mismatch), int'(exp_mis));
                    check("err_cnt", int'(bif.o_err_cnt), exp_err);
                end
            end else begin
                check("idle_mismatch", int'(bif.o_mismatch), 0);
            end
            if (bif.o_mismatch) begin
                mis_cnt++;
                mis_cyc = cyc;
            end
            prev_chk = int'(bif.o_chk_cnt);
        end
    end

    // Called at a negedge: asserts reset mid-cycle and checks outputs clear at once.
    task automatic do_reset();
        #2;
        rst = 1'b1;
        bif.i_valid = 0; bif.i_end = 0; bif.i_arg0 = 0; bif.i_arg1 = 0; bif.i_oper = 0;
        sif.i_valid = 0; sif.i_end = 0; sif.i_arg0 = 0; sif.i_arg1 = 0; sif.i_oper = 0;
        sif.i_result = 0; sif.i_flag = 0;
        sb_q.delete();
        resp.delete();
        ended   = 0;
        exp_err = 0;
        mis_cnt = 0;
        mis_cyc = -1;
        #1;
        check("rst_status", int'(bif.o_status), 0);
        check("rst_chk", int'(bif.o_chk_cnt), 0);
        check("rst_err", int'(bif.o_err_cnt), 0);
        check("rst_mismatch", int'(bif.o_mismatch), 0);
        check("rst_sat_chk", int'(sif.o_chk_cnt), 0);
        check("rst_sat_err", int'(sif.o_err_cnt), 0);
        check("rst_sat_mismatch", int'(sif.o_mismatch), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // One cycle of stimulus; r is what the ALU stand-in returns LAT cycles later.
    task automatic step(input bit v, input bit e, input logic [3:0] a, input logic [3:0] b,
                        input logic [1:0] op, input logic [7:0] r);
        bif.i_valid = v;
        bif.i_end   = e;
        bif.i_arg0  = a;
        bif.i_arg1  = b;
        bif.i_oper  = op;
        if (v && !ended) begin
            resp[cyc + LAT] = r;
            sb_q.push_back(r != ref_alu(a, b, op));
        end
        if (e) ended = 1;
        @(negedge clk);
    endtask

    task automatic issue_rand(input bit e, input bit fault);
        logic [3:0] a, b;
        logic [1:0] op;
        a  = 4'($urandom);
        b  = 4'($urandom);
        op = 2'($urandom);
        step(1, e, a, b, op, ref_alu(a, b, op) ^ (fault ? 8'h01 : 8'h00));
    endtask

    // After the i_end cycle: status stays RUN for LAT cycles (with i_valid noise), then verdict.
    task automatic drain_check(input int fin, input int nchk, input int nerr);
        for (int k = 0; k < LAT; k++) begin
            check("drain_status", int'(bif.o_status), 1);
            step(1, 0, 4'($urandom), 4'($urandom), 2'($urandom), 8'h00);
        end
        #1;
        check("final_status", int'(bif.o_status), fin);
        check("final_chk", int'(bif.o_chk_cnt), nchk);
        check("final_err", int'(bif.o_err_cnt), nerr);
        check("sb_empty", sb_q.size(), 0);
    endtask

    initial begin
        int c10;
        rst = 1'b1;
        bif.i_valid = 0; bif.i_end = 0;
        sif.i_valid = 0; sif.i_end = 0;
        do_reset();

        // directed operations with literal ALU responses
        step(1, 0, 4'b0101, 4'b0011, 2'd0, 8'b0100_0010);
        step(1, 0, 4'b1111, 4'b0000, 2'd1, 8'b0010_1111);
        step(1, 0, 4'b1100, 4'b0000, 2'd2, 8'b0100_0010);
        step(1, 1, 4'b0010, 4'b0000, 2'd3, 8'b0100_0001);
        drain_check(2, 4, 0);

        // overflow and illegal decode input
        do_reset();
        step(1, 0, 4'b1000, 4'b0001, 2'd0, 8'b1100_0111);
        step(1, 1, 4'b0110, 4'b0000, 2'd3, 8'b0001_0000);
        drain_check(2, 2, 0);
        check("ovf_no_mismatch", mis_cnt, 0);

        // end while idle
        do_reset();
        step(0, 1, 4'd0, 4'd0, 2'd0, 8'h00);
        drain_check(2, 0, 0);

        // single fault at issue index 10
        do_reset();
        c10 = 0;
        for (int i = 0; i < 20; i++) begin
            if (i == 10) c10 = cyc;
            issue_rand(i == 19, i == 10);
        end
        drain_check(3, 20, 1);
        check("fault_pulses", mis_cnt, 1);
        check("fault_pulse_cycle", mis_cyc, c10 + LAT + 1);

        // back-to-back random throughput, i_valid ignored while draining
        do_reset();
        for (int i = 0; i < 50; i++) issue_rand(i == 49, 0);
        drain_check(2, 50, 0);

        // counter saturation on the narrow-counter instance
        do_reset();
        sif.i_result = 4'h1;
        sif.i_valid  = 1;
        repeat (20) @(negedge clk);
        sif.i_valid = 0;
        repeat (LAT + 3) @(negedge clk);
        check("sat_chk", int'(sif.o_chk_cnt), 15);
        check("sat_err", int'(sif.o_err_cnt), 15);
        repeat (4) @(negedge clk);
        check("sat_chk_hold", int'(sif.o_chk_cnt), 15);
        check("sat_err_hold", int'(sif.o_err_cnt), 15);
        sif.i_valid = 1;
        repeat (LAT) @(negedge clk);
        do_reset();
        for (int k = 0; k < 6; k++) begin
            check("post_rst_mismatch", int'(sif.o_mismatch), 0);
            check("post_rst_chk", int'(sif.o_chk_cnt), 0);
            @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
